// File: rtl/seg7_digit_scanner.sv
// seg7_digit_scanner: time-multiplexed 7-segment driver.
// Stage 1 holds the scan position (cnt, idx) and a per-frame snapshot of the
// digits; stage 2 registers the anode/segment/dp drive computed from stage 1.
module seg7_digit_scanner #(
    parameter int NUM_DIGITS   = 6,
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lzb_en,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic                      frame_start
);

    localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    // XOR masks that turn active-high internal values into pin polarity;
    // they are also the inactive pin levels.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF  = ACTIVE_LOW;

    // Active-high segment patterns {g,f,e,d,c,b,a}; non-BCD shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    // ---------------- stage 1: scan position and snapshot ----------------
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]    snap_dig_q;
    logic [NUM_DIGITS-1:0]         snap_dp_q;
    logic                          snap_lzb_q;
    logic                          load_d;
    logic                          frame_start_q, frame_start_d;

    // Next scan position; snapshot is transparent while disabled and
    // otherwise refreshes only on the wrap into (0,0).
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        load_d        = 1'b0;
        frame_start_d = 1'b0;
        if (!ena) begin
            cnt_d  = '0;
            idx_d  = '0;
            load_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d         = '0;
                load_d        = 1'b1;
                frame_start_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stage-1 registers: position, frame pulse and snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
            snap_dig_q    <= '0;
            snap_dp_q     <= '0;
            snap_lzb_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
            if (load_d) begin
                snap_dig_q <= digits_in;
                snap_dp_q  <= dp_in;
                snap_lzb_q <= lzb_en;
            end
        end
    end

    // ---------------- stage 2: output drive ----------------
    logic [NUM_DIGITS-1:0] lzb_blank;
    logic                  tail_zero;
    logic [NUM_DIGITS-1:0] an_act;
    logic [6:0]            seg_act;
    logic                  dp_act;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Leading-zero mask: walk down from the top digit while every digit and
    // dp seen so far is clear. Digit 0 is always shown.
    always_comb begin
        lzb_blank = '0;
        tail_zero = snap_lzb_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            tail_zero    = tail_zero && (snap_dig_q[i] == 4'd0) && !snap_dp_q[i];
            lzb_blank[i] = tail_zero;
        end
    end

    // Drive for the current slot; guard cycles and disabled state are dark.
    always_comb begin
        an_act  = '0;
        seg_act = '0;
        dp_act  = 1'b0;
        if (ena && (int'(cnt_q) >= BLANK_CYCLES)) begin
            an_act[idx_q] = 1'b1;
            if (!lzb_blank[idx_q])
                seg_act = decode(snap_dig_q[idx_q]);
            dp_act = snap_dp_q[idx_q];
        end
        an_d  = an_act  ^ AN_OFF;
        seg_d = seg_act ^ SEG_OFF;
        dp_d  = dp_act  ^ DP_OFF;
    end

    // Output registers reset to the inactive pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_out      = an_q;
    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Bench for seg7_digit_scanner: directed scenarios plus random traffic,
// checked cycle by cycle against a frame-position reference model.
module tb_seg7_digit_scanner;

    localparam int N     = 6;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic [23:0]   digits_in = '0;
    logic [5:0]    dp_in = '0;
    logic          lzb_en = 1'b0;
    logic [5:0]    an_out;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic          frame_start;

    int errors = 0;
    int checks = 0;

    seg7_digit_scanner #(
        .NUM_DIGITS(N), .DIGIT_PERIOD(P), .BLANK_CYCLES(B), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .digits_in(digits_in), .dp_in(dp_in),
        .lzb_en(lzb_en), .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Active-high {g,f,e,d,c,b,a} shapes for 0..9, dash for 10..15.
    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model state: cycles elapsed in the current frame plus the frame's data.
    int          pos = 0;
    logic [23:0] sdig = '0;
    logic [5:0]  sdp = '0;
    logic        slzb = 1'b0;

    task automatic chk4(input string tag, input logic [5:0] ean, input logic [6:0] eseg,
                        input logic edp, input logic efs);
        checks++;
        assert (an_out === ean) else begin
            errors++; $error("FAIL %s an_out got=%b exp=%b", tag, an_out, ean);
        end
        checks++;
        assert (seg_out === eseg) else begin
            errors++; $error("FAIL %s seg_out got=%b exp=%b", tag, seg_out, eseg);
        end
        checks++;
        assert (dp_out === edp) else begin
            errors++; $error("FAIL %s dp_out got=%b exp=%b", tag, dp_out, edp);
        end
        checks++;
        assert (frame_start === efs) else begin
            errors++; $error("FAIL %s frame_start got=%b exp=%b", tag, frame_start, efs);
        end
    endtask

    // One clock: predict the outputs after the edge from the present inputs,
    // advance the model, then compare just after the edge.
    task automatic step(input string tag);
        logic [5:0] ean;
        logic [6:0] eseg;
        logic       edp, efs;
        int         slot, c;
        logic [3:0] d;
        ean = '1; eseg = '1; edp = 1'b1; efs = 1'b0;
        if (rst) begin
            pos = 0; sdig = '0; sdp = '0; slzb = 1'b0;
        end else if (!ena) begin
            pos = 0; sdig = digits_in; sdp = dp_in; slzb = lzb_en;
        end else begin
            slot = pos / P;
            c    = pos % P;
            if (c >= B) begin
                ean = ~(6'b1 << slot);
                d   = 4'(sdig >> (4 * slot));
                if (slzb && slot > 0 && (sdig >> (4 * slot)) == 0 && (sdp >> slot) == 0)
                    eseg = 7'h7F;
                else
                    eseg = ~pat[d];
                edp = ~sdp[slot];
            end
            if (pos == FRAME - 1) begin
                pos = 0; efs = 1'b1;
                sdig = digits_in; sdp = dp_in; slzb = lzb_en;
            end else begin
                pos++;
            end
        end
        @(posedge clk); #1;
        chk4(tag, ean, eseg, edp, efs);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Advance until the model sits at frame position p (bounded).
    task automatic run_to(input string tag, input int p);
        int guard = 0;
        while (pos != p && guard < 2 * FRAME) begin
            step(tag);
            guard++;
        end
        checks++;
        assert (pos == p) else begin
            errors++; $error("FAIL %s run_to got=%0d exp=%0d", tag, pos, p);
        end
    endtask

    function automatic logic [23:0] rand_digits();
        logic [23:0] v = '0;
        for (int k = 0; k < 6; k++)
            if ($urandom_range(0, 1) != 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int fs_cnt;
        // Reset state, visible asynchronously before any clock edge
        #1 rst = 1'b1;
        #2 chk4("reset_async", 6'h3F, 7'h7F, 1'b1, 1'b0);
        step("reset_hold");
        step("reset_hold");
        rst = 1'b0;
        digits_in = 24'h123456; dp_in = '0; lzb_en = 1'b0;
        step("idle");
        ena = 1'b1;

        // 1: plain scan of 123456, including explicit first-slot spot checks
        run("scan", B + 1);
        chk4("scan_slot0", 6'b111110, 7'b0000010, 1'b1, 1'b0);
        run("scan", 2 * FRAME);

        // 2: leading-zero blanking with 000070, then same value without it
        digits_in = 24'h000070; lzb_en = 1'b1;
        run("lzb70", 2 * FRAME);
        lzb_en = 1'b0;
        run("nolzb70", 2 * FRAME);

        // 3: dp on digit 2 stops blanking there
        digits_in = 24'h000100; dp_in = 6'b000100; lzb_en = 1'b1;
        run("lzb_dp", 2 * FRAME);

        // 4: mid-frame input changes; exactly one frame_start per frame
        for (int f = 0; f < 4; f++) begin
            fs_cnt = 0;
            for (int i = 0; i < FRAME; i++) begin
                if (pos == 3 * P + 1) begin
                    digits_in = rand_digits(); dp_in = 6'($urandom);
                    lzb_en = 1'($urandom);
                end
                step("midframe");
                if (frame_start === 1'b1) fs_cnt++;
            end
            checks++;
            assert (fs_cnt == 1) else begin
                errors++; $error("FAIL fs_per_frame got=%0d exp=1", fs_cnt);
            end
        end

        // 5: ena low in the middle of slot 4, then back high
        run_to("pre_enalow", 4 * P + 3);
        ena = 1'b0;
        step("ena_low");
        chk4("ena_low_dark", 6'h3F, 7'h7F, 1'b1, 1'b0);
        digits_in = rand_digits(); dp_in = 6'($urandom); lzb_en = 1'b0;
        step("ena_low");
        ena = 1'b1;
        run("ena_restart", FRAME + 12);

        // ena falls on the exact wrap cycle: no frame_start
        run_to("pre_wrapfall", FRAME - 1);
        ena = 1'b0;
        step("wrap_fall");
        checks++;
        assert (frame_start === 1'b0) else begin
            errors++; $error("FAIL wrap_fall frame_start got=%b exp=0", frame_start);
        end
        ena = 1'b1;
        run("after_wrapfall", FRAME);

        // 6: dash for 0xB, then reset in the middle of a slot
        digits_in = 24'h00000B; dp_in = '0; lzb_en = 1'b1;
        ena = 1'b0;
        step("dash_load");
        ena = 1'b1;
        run("dash", B + 1);
        chk4("dash_slot0", 6'b111110, 7'b0111111, 1'b1, 1'b0);
        run("dash", 3 * P);
        rst = 1'b1;
        #2 chk4("rst_mid_async", 6'h3F, 7'h7F, 1'b1, 1'b0);
        step("rst_mid");
        rst = 1'b0;
        run("after_rst", 2 * FRAME);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                digits_in = rand_digits(); dp_in = 6'($urandom_range(0, 3) == 0 ? $urandom : 0);
                lzb_en = 1'($urandom);
            end
            ena = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step("random");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
